// File: rtl/signal_conflict_monitor_if.sv
// Lamp-code bus between the signal controller, the conflict monitor and the lamp drivers.
// With CONFLICT_MON_STATS_EN defined the bus also carries the 8-bit fault entry counter.
interface signal_conflict_monitor_if #(
  parameter int N_VEH = 4,
  parameter int N_PED = 10
);
  logic [3*N_VEH-1:0] veh_i;
  logic [3*N_PED-1:0] ped_i;
  logic               clr_i;
  logic [3*N_VEH-1:0] veh_o;
  logic [3*N_PED-1:0] ped_o;
  logic               fault_o;
  logic [2:0]         fault_code_o;
`ifdef CONFLICT_MON_STATS_EN
  logic [7:0]         fault_cnt_o;

  modport master (
    output veh_i, ped_i, clr_i,
    input  veh_o, ped_o, fault_o, fault_code_o, fault_cnt_o
  );

  modport slave (
    input  veh_i, ped_i, clr_i,
    output veh_o, ped_o, fault_o, fault_code_o, fault_cnt_o
  );
`else
  modport master (
    output veh_i, ped_i, clr_i,
    input  veh_o, ped_o, fault_o, fault_code_o
  );

  modport slave (
    input  veh_i, ped_i, clr_i,
    output veh_o, ped_o, fault_o, fault_code_o
  );
`endif
endinterface

// File: rtl/signal_conflict_monitor.sv
// Safety output stage: registers legal lamp codes through, latches a flashing-amber fault.
// Optional CONFLICT_MON_STATS_EN adds a saturating 8-bit count of fault entries.
//
// state   | meaning
// PASS    | inputs legal, registered pass-through
// SUSPECT | violation seen, filtering for FILT_CYC consecutive samples
// FAULT   | vehicles flash amber, pedestrians dark, wait for clear
// RECOVER | all-red hold after reset or clear
module signal_conflict_monitor #(
  parameter int N_VEH       = 4,
  parameter int N_PED       = 10,
  parameter int FILT_CYC    = 4,
  parameter int FLASH_HALF  = 8,
  parameter int RECOVER_CYC = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  signal_conflict_monitor_if.slave mon
);

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] AMB = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  localparam int SLOT_F1 = 0;
  localparam int SLOT_F2 = 1;
  localparam int SLOT_F6 = 2;
  localparam int SLOT_F9 = 3;

  localparam int CNT_MAX_A = (FILT_CYC > FLASH_HALF) ? FILT_CYC : FLASH_HALF;
  localparam int CNT_MAX   = (CNT_MAX_A > RECOVER_CYC) ? CNT_MAX_A : RECOVER_CYC;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] FILT_LAST  = CNT_W'(FILT_CYC - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST = CNT_W'(FLASH_HALF - 1);
  localparam logic [CNT_W-1:0] REC_LAST   = CNT_W'(RECOVER_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_PASS    = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_FAULT   = 2'd2,
    ST_RECOVER = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               phase_q, phase_d;
  logic [3*N_VEH-1:0] veh_q, veh_d;
  logic [3*N_PED-1:0] ped_q, ped_d;
  logic               fault_q, fault_d;
  logic [2:0]         code_q, code_d;

  logic               bad_veh, bad_ped, conflict, viol;
  logic [2:0]         cause;
  logic               enter_fault;

  function automatic logic is_legal(input logic [2:0] c);
    return (c == RED) || (c == AMB) || (c == GRN);
  endfunction

  always_comb begin
    bad_veh = 1'b0;
    bad_ped = 1'b0;
    for (int i = 0; i < N_VEH; i++) begin
      if (!is_legal(mon.veh_i[3*i +: 3])) bad_veh = 1'b1;
    end
    for (int k = 0; k < N_PED; k++) begin
      if (!is_legal(mon.ped_i[3*k +: 3])) bad_ped = 1'b1;
    end
    // F1/F6 and F2/F9 are the two mutually exclusive movement groups.
    conflict = ((mon.veh_i[3*SLOT_F1 +: 3] != RED) || (mon.veh_i[3*SLOT_F6 +: 3] != RED)) &&
               ((mon.veh_i[3*SLOT_F2 +: 3] != RED) || (mon.veh_i[3*SLOT_F9 +: 3] != RED));
    cause = {conflict, bad_ped, bad_veh};
    viol  = |cause;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RECOVER;
      cnt_q   <= '0;
      phase_q <= 1'b1;
      veh_q   <= {N_VEH{RED}};
      ped_q   <= {N_PED{RED}};
      fault_q <= 1'b0;
      code_q  <= 3'b000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      veh_q   <= veh_d;
      ped_q   <= ped_d;
      fault_q <= fault_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    phase_d     = phase_q;
    enter_fault = 1'b0;
    unique case (state_q)
      ST_PASS: begin
        if (viol) begin
          state_d = ST_SUSPECT;
          cnt_d   = CNT_ONE;
        end
      end
      ST_SUSPECT: begin
        if (!viol) begin
          state_d = ST_PASS;
          cnt_d   = '0;
        end else if (cnt_q == FILT_LAST) begin
          enter_fault = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_FAULT: begin
        if (mon.clr_i && !viol) begin
          state_d = ST_RECOVER;
          cnt_d   = '0;
        end else if (cnt_q == FLASH_LAST) begin
          cnt_d   = '0;
          phase_d = ~phase_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RECOVER: begin
        if (viol) begin
          enter_fault = 1'b1;
        end else if (cnt_q == REC_LAST) begin
          state_d = ST_PASS;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_RECOVER;
        cnt_d   = '0;
      end
    endcase
    if (enter_fault) begin
      state_d = ST_FAULT;
      cnt_d   = '0;
      phase_d = 1'b1;
    end
  end

  // Lamp drive follows the state being left, so entry edges still show the old drive.
  always_comb begin
    veh_d   = {N_VEH{RED}};
    ped_d   = {N_PED{RED}};
    fault_d = fault_q;
    code_d  = code_q;
    unique case (state_q)
      ST_PASS, ST_SUSPECT: begin
        veh_d = mon.veh_i;
        ped_d = mon.ped_i;
      end
      ST_FAULT: begin
        veh_d = phase_q ? {N_VEH{AMB}} : '0;
        ped_d = '0;
      end
      default: begin
        veh_d = {N_VEH{RED}};
        ped_d = {N_PED{RED}};
      end
    endcase
    if (enter_fault) begin
      fault_d = 1'b1;
      code_d  = cause;
    end else if (state_q == ST_RECOVER && state_d == ST_PASS) begin
      fault_d = 1'b0;
      code_d  = 3'b000;
    end
  end

  assign mon.veh_o        = veh_q;
  assign mon.ped_o        = ped_q;
  assign mon.fault_o      = fault_q;
  assign mon.fault_code_o = code_q;

`ifdef CONFLICT_MON_STATS_EN
  logic [7:0] fault_cnt_q, fault_cnt_d;

  always_comb begin
    fault_cnt_d = fault_cnt_q;
    if (enter_fault && fault_cnt_q != 8'hFF) fault_cnt_d = fault_cnt_q + 8'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) fault_cnt_q <= 8'd0;
    else         fault_cnt_q <= fault_cnt_d;
  end

  assign mon.fault_cnt_o = fault_cnt_q;
`endif

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Directed bench for signal_conflict_monitor with hand-computed expected lamp drive.
module tb_signal_conflict_monitor;

  localparam int N_VEH = 4;
  localparam int N_PED = 10;

  localparam logic [11:0] VEH_RED   = {4{3'b100}};
  localparam logic [11:0] VEH_AMB   = {4{3'b010}};
  // slot order {F9, F6, F2, F1}
  localparam logic [11:0] VEH_CLEAN = {3'b100, 3'b001, 3'b100, 3'b001};
  localparam logic [11:0] VEH_ALT   = {3'b100, 3'b010, 3'b100, 3'b010};
  localparam logic [11:0] VEH_CONF  = {3'b100, 3'b001, 3'b001, 3'b001};
  localparam logic [11:0] VEH_F9BAD = {3'b000, 3'b100, 3'b100, 3'b100};
  localparam logic [29:0] PED_RED   = {10{3'b100}};
  localparam logic [29:0] PED_CLEAN = {{9{3'b100}}, 3'b001};

  logic clk_i;
  logic rst_ni;
  int   n_checks;
  int   n_errors;
  logic [29:0] ped_bad;

  signal_conflict_monitor_if #(.N_VEH(N_VEH), .N_PED(N_PED)) bus ();

  signal_conflict_monitor #(.N_VEH(N_VEH), .N_PED(N_PED)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .mon    (bus.slave)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [11:0] v, input logic [29:0] p);
    bus.veh_i = v;
    bus.ped_i = p;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    ped_bad   = PED_CLEAN;
    ped_bad[14:12] = 3'b011;
    rst_ni    = 1'b0;
    bus.clr_i = 1'b0;
    drive(VEH_CLEAN, PED_CLEAN);
    #12;
    check_eq("rst_veh", 64'(bus.veh_o), 64'(VEH_RED));
    check_eq("rst_ped", 64'(bus.ped_o), 64'(PED_RED));
    check_eq("rst_fault", 64'(bus.fault_o), 64'd0);
    check_eq("rst_code", 64'(bus.fault_code_o), 64'd0);
    rst_ni = 1'b1;

    // power-up all-red hold, then pass-through
    step(16);
    check_eq("hold16_veh", 64'(bus.veh_o), 64'(VEH_RED));
    step(1);
    check_eq("pass_veh", 64'(bus.veh_o), 64'(VEH_CLEAN));
    check_eq("pass_ped", 64'(bus.ped_o), 64'(PED_CLEAN));
    check_eq("pass_fault", 64'(bus.fault_o), 64'd0);
    drive(VEH_ALT, PED_RED);
    step(1);
    check_eq("alt_veh", 64'(bus.veh_o), 64'(VEH_ALT));
    check_eq("alt_ped", 64'(bus.ped_o), 64'(PED_RED));

    // conflict held 3 samples is filtered out
    drive(VEH_CONF, PED_CLEAN);
    step(1);
    check_eq("susp_passthru", 64'(bus.veh_o), 64'(VEH_CONF));
    step(2);
    check_eq("conf3_fault", 64'(bus.fault_o), 64'd0);
    drive(VEH_CLEAN, PED_CLEAN);
    step(1);
    check_eq("conf3_back", 64'(bus.veh_o), 64'(VEH_CLEAN));
    check_eq("conf3_nofault", 64'(bus.fault_o), 64'd0);

    // conflict held 4 samples latches a fault
    drive(VEH_CONF, PED_CLEAN);
    step(3);
    check_eq("conf4_pre", 64'(bus.fault_o), 64'd0);
    step(1);
    check_eq("conf4_fault", 64'(bus.fault_o), 64'd1);
    check_eq("conf4_code", 64'(bus.fault_code_o), 64'b100);
    drive(VEH_CLEAN, PED_CLEAN);
    step(1);
    check_eq("flash_on1", 64'(bus.veh_o), 64'(VEH_AMB));
    check_eq("flash_ped", 64'(bus.ped_o), 64'd0);
    step(7);
    check_eq("flash_on8", 64'(bus.veh_o), 64'(VEH_AMB));
    step(1);
    check_eq("flash_off1", 64'(bus.veh_o), 64'd0);
    step(7);
    check_eq("flash_off8", 64'(bus.veh_o), 64'd0);
    step(1);
    check_eq("flash_on_again", 64'(bus.veh_o), 64'(VEH_AMB));

    // clear, then an unfiltered fault during the all-red hold
    bus.clr_i = 1'b1;
    step(1);
    bus.clr_i = 1'b0;
    check_eq("clr_fault_held", 64'(bus.fault_o), 64'd1);
    step(1);
    check_eq("recover_red", 64'(bus.veh_o), 64'(VEH_RED));
    drive(VEH_F9BAD, PED_CLEAN);
    step(1);
    check_eq("rec_fault", 64'(bus.fault_o), 64'd1);
    check_eq("rec_code", 64'(bus.fault_code_o), 64'b001);
    check_eq("rec_entry_red", 64'(bus.veh_o), 64'(VEH_RED));
    drive(VEH_CLEAN, PED_CLEAN);
    step(1);
    check_eq("rec_flash", 64'(bus.veh_o), 64'(VEH_AMB));

    bus.clr_i = 1'b1;
    step(1);
    bus.clr_i = 1'b0;
    step(15);
    check_eq("rec15_fault", 64'(bus.fault_o), 64'd1);
    check_eq("rec15_veh", 64'(bus.veh_o), 64'(VEH_RED));
    step(1);
    check_eq("rec16_fault", 64'(bus.fault_o), 64'd0);
    check_eq("rec16_code", 64'(bus.fault_code_o), 64'd0);
    step(1);
    check_eq("rec17_veh", 64'(bus.veh_o), 64'(VEH_CLEAN));

    // invalid pedestrian code; clear refused while still invalid
    drive(VEH_CLEAN, ped_bad);
    step(3);
    check_eq("ped3_fault", 64'(bus.fault_o), 64'd0);
    step(1);
    check_eq("ped4_fault", 64'(bus.fault_o), 64'd1);
    check_eq("ped4_code", 64'(bus.fault_code_o), 64'b010);
    bus.clr_i = 1'b1;
    step(1);
    check_eq("ped_clr_bad_fault", 64'(bus.fault_o), 64'd1);
    check_eq("ped_clr_bad_code", 64'(bus.fault_code_o), 64'b010);
    check_eq("ped_clr_bad_dark", 64'(bus.ped_o), 64'd0);
    drive(VEH_CLEAN, PED_CLEAN);
    step(1);
    bus.clr_i = 1'b0;
    step(1);
    check_eq("ped_rec_veh", 64'(bus.veh_o), 64'(VEH_RED));
    check_eq("ped_rec_ped", 64'(bus.ped_o), 64'(PED_RED));
    check_eq("ped_rec_fault", 64'(bus.fault_o), 64'd1);
    step(15);
    check_eq("ped_rec16_fault", 64'(bus.fault_o), 64'd0);
    step(1);
    check_eq("ped_rec17_ped", 64'(bus.ped_o), 64'(PED_CLEAN));

    // asynchronous reset in the middle of a fault
    drive(VEH_CONF, PED_CLEAN);
    step(4);
    drive(VEH_CLEAN, PED_CLEAN);
    step(2);
    check_eq("pre_rst_flash", 64'(bus.veh_o), 64'(VEH_AMB));
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("async_rst_veh", 64'(bus.veh_o), 64'(VEH_RED));
    check_eq("async_rst_ped", 64'(bus.ped_o), 64'(PED_RED));
    check_eq("async_rst_fault", 64'(bus.fault_o), 64'd0);
    check_eq("async_rst_code", 64'(bus.fault_code_o), 64'd0);
    rst_ni = 1'b1;
    step(16);
    check_eq("post_rst16_veh", 64'(bus.veh_o), 64'(VEH_RED));
    step(1);
    check_eq("post_rst17_veh", 64'(bus.veh_o), 64'(VEH_CLEAN));

`ifdef CONFLICT_MON_STATS_EN
    // fault entry counter: starts at zero after the reset above
    check_eq("cnt_after_rst", 64'(bus.fault_cnt_o), 64'd0);
    rst_ni = 1'b0;
    #1;
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(VEH_F9BAD, PED_CLEAN);
      step(1);
      drive(VEH_CLEAN, PED_CLEAN);
      bus.clr_i = 1'b1;
      step(1);
      bus.clr_i = 1'b0;
    end
    check_eq("cnt_3", 64'(bus.fault_cnt_o), 64'd3);
    bus.clr_i = 1'b1;
    step(2);
    bus.clr_i = 1'b0;
    check_eq("cnt_clr_keep", 64'(bus.fault_cnt_o), 64'd3);
    for (int i = 0; i < 297; i++) begin
      drive(VEH_F9BAD, PED_CLEAN);
      step(1);
      drive(VEH_CLEAN, PED_CLEAN);
      bus.clr_i = 1'b1;
      step(1);
      bus.clr_i = 1'b0;
    end
    check_eq("cnt_sat", 64'(bus.fault_cnt_o), 64'd255);
    #2;
    rst_ni = 1'b0;
    #1;
    check_eq("cnt_rst", 64'(bus.fault_cnt_o), 64'd0);
    rst_ni = 1'b1;
`endif

    step(2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
